uc_pipe_hold: RTL and testbench

UC_PIPE_HOLD -- requirements
Module: uc_pipe_hold

---
 rtl/uc_pipe_hold_pkg.sv | 15 +
 rtl/uc_pipe_hold.sv | 100 ++++++++++
 tb/tb_uc_pipe_hold.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uc_pipe_hold_pkg.sv
// Shared control-unit definitions for the pipeline hold controller:
// state encoding, register-address width and the default forced-release limit.
package uc_pipe_hold_pkg;

  localparam int REG_ADDR_W       = 6;
  localparam int MAX_WAIT_DEFAULT = 15;
  localparam int STALL_CNT_W      = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } holdState_t;

endpackage

// File: rtl/uc_pipe_hold.sv
// Pipeline hold controller: freezes fetch/operand stages while a register
// write is outstanding, releases on the matching write-back or after MAX_WAIT cycles.
module uc_pipe_hold
  import uc_pipe_hold_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold_registers,
  input  logic                   exec_write,
  input  logic [REG_ADDR_W-1:0]  exec_dest,
  input  logic                   wb_done,
  input  logic [REG_ADDR_W-1:0]  wb_dest,
  output logic                   fetch_en,
  output logic                   operand_en,
  output logic                   bubble,
  output logic                   stall_active,
  output logic                   timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

  holdState_t            state;
  holdState_t            nextState;
  logic [REG_ADDR_W-1:0] pendDest;
  logic [7:0]            waitCnt;
  logic                  timeoutReg;
  logic [STALL_CNT_W-1:0] stallCnt;

  logic startStall;
  logic pendMatch;
  logic limitHit;

  // A hazard only stalls if the conflicting write is not already landing this edge.
  always_comb begin
    startStall = hold_registers && exec_write && !(wb_done && (wb_dest == exec_dest));
    pendMatch  = wb_done && (wb_dest == pendDest);
    limitHit   = (waitCnt == WAIT_LIMIT);
    nextState  = state;
    case (state)
      RUN:     if (startStall) nextState = STALL;
      STALL:   if (pendMatch || limitHit) nextState = DRAIN;
      DRAIN:   nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Matching write-back beats the wait limit, so timeout only fires on a true forced release.
  always_ff @(posedge clk) begin
    if (reset) begin
      pendDest   <= '0;
      waitCnt    <= '0;
      timeoutReg <= 1'b0;
      stallCnt   <= '0;
    end else begin
      if (state == RUN && startStall) begin
        pendDest <= exec_dest;
        waitCnt  <= '0;
      end else if (state == STALL) begin
        waitCnt <= waitCnt + 8'd1;
      end
      timeoutReg <= (state == STALL) && limitHit && !pendMatch;
      if (state == STALL && stallCnt != {STALL_CNT_W{1'b1}}) begin
        stallCnt <= stallCnt + 1'b1;
      end
    end
  end

  always_comb begin
    fetch_en     = 1'b1;
    operand_en   = 1'b1;
    bubble       = 1'b0;
    stall_active = 1'b0;
    case (state)
      STALL: begin
        fetch_en     = 1'b0;
        operand_en   = 1'b0;
        bubble       = 1'b1;
        stall_active = 1'b1;
      end
      DRAIN: begin
        fetch_en = 1'b0;
      end
      default: ;
    endcase
    timeout     = timeoutReg;
    stall_count = stallCnt;
  end

endmodule

// File: tb/tb_uc_pipe_hold.sv
// Directed bench for uc_pipe_hold: a table of single-edge vectors followed by
// hand-written multi-cycle sequences for timeout, tie-break and saturation.
module tb_uc_pipe_hold;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold_registers;
  logic       exec_write;
  logic [5:0] exec_dest;
  logic       wb_done;
  logic [5:0] wb_dest;
  logic       fetch_en;
  logic       operand_en;
  logic       bubble;
  logic       stall_active;
  logic       timeout;
  logic [7:0] stall_count;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  uc_pipe_hold #(.MAX_WAIT(15)) dut (
    .clk(clk),
    .reset(reset),
    .hold_registers(hold_registers),
    .exec_write(exec_write),
    .exec_dest(exec_dest),
    .wb_done(wb_done),
    .wb_dest(wb_dest),
    .fetch_en(fetch_en),
    .operand_en(operand_en),
    .bubble(bubble),
    .stall_active(stall_active),
    .timeout(timeout),
    .stall_count(stall_count)
  );

  typedef struct {
    logic       rst;
    logic       hold;
    logic       ew;
    logic [5:0] ed;
    logic       wd;
    logic [5:0] wdst;
    logic [4:0] flags;   // {fetch_en, operand_en, bubble, stall_active, timeout}
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] F_RUN   = 5'b11000;
  localparam logic [4:0] F_STALL = 5'b00110;
  localparam logic [4:0] F_DRAIN = 5'b01000;
  localparam logic [4:0] F_TOUT  = 5'b01001;

  function automatic vec_t mk(logic rst, logic hold, logic ew, logic [5:0] ed,
                              logic wd, logic [5:0] wdst, logic [4:0] flags, logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.hold = hold; v.ew = ew; v.ed = ed;
    v.wd = wd; v.wdst = wdst; v.flags = flags; v.cnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic rst, input logic hold, input logic ew, input logic [5:0] ed,
                       input logic wd, input logic [5:0] wdst);
    reset = rst; hold_registers = hold; exec_write = ew; exec_dest = ed;
    wb_done = wd; wb_dest = wdst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.rst, v.hold, v.ew, v.ed, v.wd, v.wdst);
    step();
  endtask

  // Stall on dest, feed only non-matching write-backs, count STALL cycles until release.
  task automatic runTimeoutStall(input logic [5:0] dest, output int cycles, output logic sawTimeout);
    drive(1'b0, 1'b1, 1'b1, dest, 1'b0, 6'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, dest ^ 6'h01);
    cycles = 0;
    while (stall_active && cycles < 300) begin
      cycles++;
      step();
    end
    sawTimeout = timeout;
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    step();
  endtask

  initial begin
    int   cycles;
    logic sawTo;

    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);

    //               rst  hold ew  ed    wd  wdst   flags    cnt
    vecs.push_back(mk(1, 0, 0, 6'd0, 0, 6'd0, F_RUN,   8'd0));
    vecs.push_back(mk(0, 0, 0, 6'd0, 0, 6'd0, F_RUN,   8'd0));
    vecs.push_back(mk(0, 1, 1, 6'd5, 0, 6'd0, F_STALL, 8'd0));
    vecs.push_back(mk(0, 0, 0, 6'd0, 0, 6'd0, F_STALL, 8'd1));
    vecs.push_back(mk(0, 0, 0, 6'd0, 0, 6'd0, F_STALL, 8'd2));
    vecs.push_back(mk(0, 0, 0, 6'd0, 1, 6'd5, F_DRAIN, 8'd3));
    vecs.push_back(mk(0, 1, 1, 6'd3, 0, 6'd0, F_RUN,   8'd3));
    vecs.push_back(mk(0, 1, 1, 6'd9, 1, 6'd9, F_RUN,   8'd3));
    vecs.push_back(mk(0, 1, 0, 6'd4, 0, 6'd0, F_RUN,   8'd3));
    vecs.push_back(mk(0, 1, 1, 6'd2, 0, 6'd0, F_STALL, 8'd3));
    vecs.push_back(mk(0, 0, 0, 6'd0, 1, 6'd3, F_STALL, 8'd4));
    vecs.push_back(mk(0, 1, 1, 6'd4, 0, 6'd0, F_STALL, 8'd5));
    vecs.push_back(mk(0, 0, 0, 6'd0, 1, 6'd2, F_DRAIN, 8'd6));
    vecs.push_back(mk(0, 0, 0, 6'd0, 0, 6'd0, F_RUN,   8'd6));
    vecs.push_back(mk(0, 1, 1, 6'd1, 0, 6'd0, F_STALL, 8'd6));
    vecs.push_back(mk(0, 0, 0, 6'd0, 0, 6'd0, F_STALL, 8'd7));
    vecs.push_back(mk(1, 0, 0, 6'd0, 0, 6'd0, F_RUN,   8'd0));
    vecs.push_back(mk(0, 1, 1, 6'd1, 0, 6'd0, F_STALL, 8'd0));
    vecs.push_back(mk(0, 0, 0, 6'd0, 1, 6'd1, F_DRAIN, 8'd1));
    vecs.push_back(mk(1, 0, 0, 6'd0, 0, 6'd0, F_RUN,   8'd0));
    vecs.push_back(mk(1, 1, 1, 6'd8, 0, 6'd0, F_RUN,   8'd0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d flags", i),
                  32'({fetch_en, operand_en, bubble, stall_active, timeout}), 32'(vecs[i].flags));
      checkOutput($sformatf("vec%0d stall_count", i), 32'(stall_count), 32'(vecs[i].cnt));
    end

    // Hazard without a pending write never stalls.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, 6'd12, 1'b0, 6'd0);
      step();
      checkOutput($sformatf("noWrite cyc%0d fetch_en", i), 32'(fetch_en), 32'd1);
    end
    checkOutput("noWrite stall_count", 32'(stall_count), 32'd0);

    // Forced release after MAX_WAIT stall cycles.
    runTimeoutStall(6'd7, cycles, sawTo);
    checkOutput("timeout stall cycles", 32'(cycles), 32'd15);
    checkOutput("timeout pulse in DRAIN", 32'(sawTo), 32'd1);
    checkOutput("timeout back to RUN", 32'({fetch_en, operand_en, bubble, stall_active, timeout}), 32'(F_RUN));
    checkOutput("timeout stall_count", 32'(stall_count), 32'd15);

    // Matching write on the same edge as the limit: release without timeout.
    drive(1'b0, 1'b1, 1'b1, 6'd7, 1'b0, 6'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    for (int i = 0; i < 14; i++) step();
    checkOutput("tie still stalled", 32'(stall_active), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd7);
    step();
    checkOutput("tie DRAIN no timeout", 32'({fetch_en, operand_en, bubble, stall_active, timeout}), 32'(F_DRAIN));
    checkOutput("tie stall_count", 32'(stall_count), 32'd30);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    step();

    // Saturation: 20 forced-release stalls of 15 cycles = 300 stall cycles.
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    step();
    for (int n = 0; n < 20; n++) begin
      runTimeoutStall(6'(n + 10), cycles, sawTo);
      if (n == 16) checkOutput("sat at 255 exactly", 32'(stall_count), 32'd255);
    end
    checkOutput("sat after 300 cycles", 32'(stall_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
